// File: rtl/dae_pkg.sv
// rtl/dae_pkg.sv - shared state encoding, instruction layout and ALU select codes
package dae_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Field order matches the 10-bit instruction word; LDI reuses {rs,rt} as imm.
    typedef struct packed {
        logic       ldi;
        logic [2:0] sel;
        logic [1:0] rd;
        logic [1:0] rs;
        logic [1:0] rt;
    } ins_t;

    localparam logic [2:0] SEL_SUB = 3'b000;
    localparam logic [2:0] SEL_ADD = 3'b001;
    localparam logic [2:0] SEL_AND = 3'b010;
    localparam logic [2:0] SEL_OR  = 3'b011;
    localparam logic [2:0] SEL_XOR = 3'b100;
    localparam logic [2:0] SEL_NOT = 3'b101;
    localparam logic [2:0] SEL_SHL = 3'b110;
    localparam logic [2:0] SEL_SHR = 3'b111;

    function automatic logic [3:0] ins_imm(input ins_t ins);
        return {ins.rs, ins.rt};
    endfunction

endpackage

// File: rtl/Decode_And_Execute.sv
// rtl/Decode_And_Execute.sv - 4-bit combinational ALU, results wrap modulo 16
module Decode_And_Execute
    import dae_pkg::*;
(
    input  logic [3:0] rs,
    input  logic [3:0] rt,
    input  logic [2:0] sel,
    output logic [3:0] rd
);

    always_comb begin
        rd = 4'h0;
        case (sel)
            SEL_SUB: rd = rs - rt;
            SEL_ADD: rd = rs + rt;
            SEL_AND: rd = rs & rt;
            SEL_OR:  rd = rs | rt;
            SEL_XOR: rd = rs ^ rt;
            SEL_NOT: rd = ~rs;
            SEL_SHL: rd = {rs[2:0], 1'b0};
            SEL_SHR: rd = {1'b0, rs[3:1]};
            default: rd = 4'h0;
        endcase
    end

endmodule

// File: rtl/dae_regfile.sv
// rtl/dae_regfile.sv - 4x4-bit register file, two async reads, one sync write
module dae_regfile (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] ra_addr,
    output logic [3:0] ra_data,
    input  logic [1:0] rb_addr,
    output logic [3:0] rb_data,
    input  logic       we,
    input  logic [1:0] wa,
    input  logic [3:0] wd
);

    logic [3:0] regs [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) regs[i] <= 4'h0;
        end else if (we) begin
            regs[wa] <= wd;
        end
    end

    assign ra_data = regs[ra_addr];
    assign rb_data = regs[rb_addr];

endmodule

// File: rtl/dae_sequencer.sv
// rtl/dae_sequencer.sv - one-at-a-time instruction sequencer around the 4-bit ALU
module dae_sequencer
    import dae_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [9:0]       in_ins,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_data,
    output logic [1:0]       out_reg,
    output logic [CNT_W-1:0] retired
);

    state_t     state;
    ins_t       ins_in;
    ins_t       ins_q;
    logic [3:0] rs_val;
    logic [3:0] rt_val;
    logic [3:0] alu_rd;
    logic [3:0] result;
    logic       wr_en;

    assign ins_in = in_ins;
    assign wr_en  = (state == ST_EXEC);
    assign result = ins_q.ldi ? ins_imm(ins_q) : alu_rd;

    // Operands are read combinationally in EXEC and written at the same edge,
    // so rd==rs/rt sees the old value.
    dae_regfile u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra_addr (ins_q.rs),
        .ra_data (rs_val),
        .rb_addr (ins_q.rt),
        .rb_data (rt_val),
        .we      (wr_en),
        .wa      (ins_q.rd),
        .wd      (result)
    );

    Decode_And_Execute u_alu (
        .rs  (rs_val),
        .rt  (rt_val),
        .sel (ins_q.sel),
        .rd  (alu_rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ins_q     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= 4'h0;
            out_reg   <= 2'd0;
            retired   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        ins_q    <= ins_in;
                        in_ready <= 1'b0;
                        state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    out_valid <= 1'b1;
                    out_data  <= result;
                    out_reg   <= ins_q.rd;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        retired   <= retired + 1'b1;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dae_sequencer.sv
// tb/tb_dae_sequencer.sv - scoreboard bench for dae_sequencer
module tb_dae_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [9:0] in_ins = 10'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_data;
    logic [1:0] out_reg;
    logic [7:0] retired;

    typedef struct packed {
        logic [3:0] d;
        logic [1:0] r;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] m_r[4];
    int         exp_ret;
    int         n_cmp = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    dae_sequencer #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ins    (in_ins),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_reg   (out_reg),
        .retired   (retired)
    );

    function automatic logic [9:0] mk(input logic [2:0] sel, input logic [1:0] rd,
                                      input logic [1:0] rs, input logic [1:0] rt);
        return {1'b0, sel, rd, rs, rt};
    endfunction

    function automatic logic [9:0] mk_ldi(input logic [1:0] rd, input logic [3:0] imm);
        return {1'b1, 3'b000, rd, imm};
    endfunction

    function automatic logic [3:0] model_alu(input logic [2:0] sel, input logic [3:0] a,
                                             input logic [3:0] b);
        case (sel)
            3'd0:    return 4'(a - b);
            3'd1:    return 4'(a + b);
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ~a;
            3'd6:    return 4'(a << 1);
            default: return a >> 1;
        endcase
    endfunction

    task automatic model_clear();
        sb.delete();
        for (int i = 0; i < 4; i++) m_r[i] = 4'h0;
        exp_ret = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
    endtask

    task automatic issue(input logic [9:0] ins, output bit to);
        exp_t       e;
        logic [3:0] v;
        int         cnt = 0;
        in_ins = ins;
        in_valid = 1'b1;
        while (!in_ready && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        to = !in_ready;
        if (!to) begin
            v = ins[9] ? ins[3:0] : model_alu(ins[8:6], m_r[ins[3:2]], m_r[ins[1:0]]);
            m_r[ins[5:4]] = v;
            e.d = v;
            e.r = ins[5:4];
            sb.push_back(e);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(output logic [3:0] d, output logic [1:0] r, output int lat, output bit to);
        int cnt = 0;
        while (!out_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        to = !out_valid;
        lat = cnt + 1;
        d = out_data;
        r = out_reg;
        if (!to) begin
            out_ready = 1'b1;
            @(posedge clk);
            exp_ret++;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    task automatic step(input logic [9:0] ins, output exp_t got, output exp_t want,
                        output int lat, output bit to);
        bit to_i;
        bit to_d;
        logic [3:0] d;
        logic [1:0] r;
        issue(ins, to_i);
        drain(d, r, lat, to_d);
        got.d = d;
        got.r = r;
        to = to_i | to_d;
        want = '0;
        if (sb.size() > 0) want = sb.pop_front();
    endtask

    task automatic test_reset();
        exp_t got, want;
        int lat;
        bit to;
        rst_n = 1'b0;
        model_clear();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold: in_ready=%b out_valid=%b required 0/0", in_ready, out_valid);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || retired !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b retired=%0d required 1/0/0",
                     in_ready, out_valid, retired);
        end
        for (int x = 0; x < 4; x++) begin
            step(mk(3'b001, 2'(x), 2'(x), 2'd0), got, want, lat, to);
            n_cmp++;
            if (to || got !== want || got.d !== 4'h0) begin
                n_fail++;
                $display("FAIL reset_reg%0d: got d=%h r=%0d required d=%h r=%0d to=%0d",
                         x, got.d, got.r, want.d, want.r, to);
            end
        end
    endtask

    task automatic test_add();
        exp_t got, want;
        int lat;
        bit to;
        do_reset();
        step(mk_ldi(2'd1, 4'd3), got, want, lat, to);
        n_cmp++;
        if (to || got !== want) begin
            n_fail++;
            $display("FAIL ldi_r1: got d=%h r=%0d required d=%h r=%0d", got.d, got.r, want.d, want.r);
        end
        step(mk_ldi(2'd2, 4'd5), got, want, lat, to);
        n_cmp++;
        if (to || got !== want) begin
            n_fail++;
            $display("FAIL ldi_r2: got d=%h r=%0d required d=%h r=%0d", got.d, got.r, want.d, want.r);
        end
        step(mk(3'b001, 2'd3, 2'd1, 2'd2), got, want, lat, to);
        n_cmp++;
        if (to || got !== want || got.d !== 4'h8 || got.r !== 2'd3) begin
            n_fail++;
            $display("FAIL add: got d=%h r=%0d required d=8 r=3", got.d, got.r);
        end
        n_cmp++;
        if (lat !== 2) begin
            n_fail++;
            $display("FAIL add_latency: got %0d cycles required 2", lat);
        end
        n_cmp++;
        if (retired !== 8'd3 || retired !== 8'(exp_ret)) begin
            n_fail++;
            $display("FAIL add_retired: got %0d required 3", retired);
        end
    endtask

    task automatic test_sub();
        exp_t got, want;
        int lat;
        bit to;
        step(mk(3'b000, 2'd0, 2'd1, 2'd2), got, want, lat, to);
        n_cmp++;
        if (to || got !== want || got.d !== 4'hE || got.r !== 2'd0) begin
            n_fail++;
            $display("FAIL sub: got d=%h r=%0d required d=e r=0", got.d, got.r);
        end
    endtask

    task automatic test_logic_ops();
        exp_t got, want;
        int lat;
        bit to;
        for (int s = 2; s < 8; s++) begin
            step(mk(3'(s), 2'd3, 2'd1, 2'd2), got, want, lat, to);
            n_cmp++;
            if (to || got !== want) begin
                n_fail++;
                $display("FAIL op_sel%0d: got d=%h r=%0d required d=%h r=%0d",
                         s, got.d, got.r, want.d, want.r);
            end
        end
    endtask

    task automatic test_backpressure();
        exp_t got, want;
        int lat;
        bit to;
        logic [3:0] d;
        logic [1:0] r;
        int cnt = 0;
        issue(mk(3'b001, 2'd3, 2'd1, 2'd1), to);
        while (!out_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        for (int c = 0; c < 5; c++) begin
            in_valid = (c == 2);
            in_ins = mk_ldi(2'd2, 4'hF);
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sb.size() == 0 || out_data !== sb[0].d) begin
                n_fail++;
                $display("FAIL bp_hold%0d: out_valid=%b in_ready=%b out_data=%h", c, out_valid, in_ready, out_data);
            end
        end
        in_valid = 1'b0;
        drain(d, r, lat, to);
        got.d = d;
        got.r = r;
        want = '0;
        if (sb.size() > 0) want = sb.pop_front();
        n_cmp++;
        if (to || got !== want) begin
            n_fail++;
            $display("FAIL bp_result: got d=%h r=%0d required d=%h r=%0d", got.d, got.r, want.d, want.r);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0 || retired !== 8'(exp_ret)) begin
                n_fail++;
                $display("FAIL bp_idle%0d: out_valid=%b retired=%0d required 0/%0d", c, out_valid, retired, exp_ret);
            end
        end
        out_ready = 1'b0;
        step(mk(3'b010, 2'd3, 2'd2, 2'd2), got, want, lat, to);
        n_cmp++;
        if (to || got !== want || got.d !== 4'h5) begin
            n_fail++;
            $display("FAIL bp_dropped: got d=%h r=%0d required d=5 r=3", got.d, got.r);
        end
    endtask

    task automatic test_hazard();
        exp_t got, want;
        int lat;
        bit to;
        do_reset();
        step(mk_ldi(2'd1, 4'd3), got, want, lat, to);
        step(mk(3'b001, 2'd1, 2'd1, 2'd1), got, want, lat, to);
        n_cmp++;
        if (to || got !== want || got.d !== 4'h6) begin
            n_fail++;
            $display("FAIL hazard_self: got d=%h required d=6", got.d);
        end
        step(mk(3'b001, 2'd2, 2'd1, 2'd0), got, want, lat, to);
        n_cmp++;
        if (to || got !== want || got.d !== 4'h6) begin
            n_fail++;
            $display("FAIL hazard_next: got d=%h required d=6", got.d);
        end
    endtask

    task automatic test_reset_mid();
        exp_t got, want;
        int lat;
        bit to;
        do_reset();
        in_ins = mk_ldi(2'd1, 4'd7);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0 || retired !== 8'd0) begin
                n_fail++;
                $display("FAIL rst_exec%0d: out_valid=%b retired=%0d required 0/0", c, out_valid, retired);
            end
        end
        in_ins = mk_ldi(2'd2, 4'd9);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || retired !== 8'd0) begin
            n_fail++;
            $display("FAIL rst_resp: out_valid=%b retired=%0d required 0/0", out_valid, retired);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
        for (int x = 1; x < 3; x++) begin
            step(mk(3'b010, 2'd0, 2'(x), 2'(x)), got, want, lat, to);
            n_cmp++;
            if (to || got !== want || got.d !== 4'h0) begin
                n_fail++;
                $display("FAIL rst_reg%0d: got d=%h required d=0", x, got.d);
            end
        end
    endtask

    task automatic test_wrap();
        exp_t got, want;
        int lat;
        bit to;
        do_reset();
        for (int i = 0; i < 256; i++) begin
            step(mk_ldi(2'(i % 4), 4'(i % 16)), got, want, lat, to);
            n_cmp++;
            if (to || got !== want) begin
                n_fail++;
                $display("FAIL wrap_ins%0d: got d=%h r=%0d required d=%h r=%0d",
                         i, got.d, got.r, want.d, want.r);
            end
            if (i == 254) begin
                n_cmp++;
                if (retired !== 8'd255) begin
                    n_fail++;
                    $display("FAIL wrap_255: got %0d required 255", retired);
                end
            end
        end
        n_cmp++;
        if (retired !== 8'd0) begin
            n_fail++;
            $display("FAIL wrap_zero: got %0d required 0", retired);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_logic_ops();
        test_backpressure();
        test_hazard();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
